// File: rtl/chip_run_pkg.sv
// Shared types for the chip run scheduler.
// State encoding and error codes.
package chip_run_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RUN       = 3'd1,
    S_GAP       = 3'd2,
    S_WAIT_ITER = 3'd3,
    S_DONE      = 3'd4,
    S_ERROR     = 3'd5
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_CFG     = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

endpackage

// File: rtl/chip_done_collector.sv
// Layer completion detector across channels.
// Completion = every enabled channel done now or earlier.
module chip_done_collector #(
  parameter int NUM_CH = 4
) (
  input  logic [NUM_CH-1:0] i_flags,
  input  logic              i_clear,
  input  logic [NUM_CH-1:0] i_mask,
  input  logic [NUM_CH-1:0] i_done,
  output logic              o_all_done
);

  logic [NUM_CH-1:0] w_seen;

  // done seen in the start-pulse cycle does not count
  assign w_seen     = (i_flags | i_done) & i_mask;
  assign o_all_done = !i_clear && (w_seen == i_mask);

endmodule

// File: rtl/chip_run_scheduler.sv
// Multi-channel layer/iteration run controller.
// Pulses layers, collects done, gaps, watchdog, abort.
module chip_run_scheduler
  import chip_run_pkg::*;
#(
  parameter int NUM_CH     = 4,
  parameter int LAYER_W    = 6,
  parameter int ITER_W     = 16,
  parameter int WAIT_W     = 16,
  parameter int CNT_W      = 31,
  parameter int DONE_CNT_W = 32,
  parameter int GAP_CYCLES = 1
) (
  input  logic                  chip_clk,
  input  logic                  rstn,
  input  logic                  start_network,
  input  logic                  abort,
  input  logic [LAYER_W-1:0]    n_layers,
  input  logic [ITER_W-1:0]     n_iter,
  input  logic [WAIT_W-1:0]     wait_cycles,
  input  logic [CNT_W-1:0]      timeout_cycles,
  input  logic [NUM_CH-1:0]     ch_mask,
  output logic [NUM_CH-1:0]     start_layer,
  input  logic [NUM_CH-1:0]     done_layer,
  output logic                  busy,
  output logic                  done_network,
  output logic                  error,
  output logic [1:0]            err_code,
  output logic [LAYER_W-1:0]    layer_idx,
  output logic [DONE_CNT_W-1:0] done_network_cnt,
  output logic [CNT_W-1:0]      clk_cnt,
  output logic [CNT_W-1:0]      last_layer_cycles
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  state_t                r_state;
  logic [LAYER_W-1:0]    r_n_layers;
  logic [ITER_W-1:0]     r_n_iter;
  logic [WAIT_W-1:0]     r_wait;
  logic [CNT_W-1:0]      r_timeout;
  logic [NUM_CH-1:0]     r_mask;
  logic [NUM_CH-1:0]     r_start_layer;
  logic                  r_pulse;
  logic [NUM_CH-1:0]     r_flags;
  logic [CNT_W-1:0]      r_layer_cnt;
  logic [GAP_W-1:0]      r_gap_cnt;
  logic [WAIT_W-1:0]     r_wait_cnt;
  logic [ITER_W-1:0]     r_iter_cnt;
  logic [LAYER_W-1:0]    r_layer_idx;
  logic [DONE_CNT_W-1:0] r_done_cnt;
  logic [CNT_W-1:0]      r_clk_cnt;
  logic [CNT_W-1:0]      r_last;
  logic                  r_error;
  logic [1:0]            r_err_code;

  logic                  w_all_done;
  logic                  w_last_layer;
  logic                  w_run_done;
  logic                  w_timeout;
  logic [ITER_W-1:0]     w_iter_next;
  logic [CNT_W-1:0]      w_clk_inc;
  logic [CNT_W-1:0]      w_layer_inc;

  chip_done_collector #(
    .NUM_CH(NUM_CH)
  ) u_collect (
    .i_flags   (r_flags),
    .i_clear   (r_pulse),
    .i_mask    (r_mask),
    .i_done    (done_layer),
    .o_all_done(w_all_done)
  );

  assign w_last_layer = (r_layer_idx == r_n_layers - LAYER_W'(1));
  assign w_iter_next  = r_iter_cnt + ITER_W'(1);
  assign w_run_done   = (r_n_iter != '0) && (w_iter_next == r_n_iter);
  assign w_timeout    = (r_timeout != '0) && (r_layer_cnt == r_timeout);
  assign w_clk_inc    = (&r_clk_cnt) ? r_clk_cnt
                                     : r_clk_cnt + CNT_W'(1);
  assign w_layer_inc  = (&r_layer_cnt) ? r_layer_cnt
                                       : r_layer_cnt + CNT_W'(1);

  // Run sequencer: state, start pulses, counters, status
  always_ff @(posedge chip_clk or negedge rstn) begin
    if (!rstn) begin
      r_state       <= S_IDLE;
      r_n_layers    <= '0;
      r_n_iter      <= '0;
      r_wait        <= '0;
      r_timeout     <= '0;
      r_mask        <= '0;
      r_start_layer <= '0;
      r_pulse       <= 1'b0;
      r_flags       <= '0;
      r_layer_cnt   <= '0;
      r_gap_cnt     <= '0;
      r_wait_cnt    <= '0;
      r_iter_cnt    <= '0;
      r_layer_idx   <= '0;
      r_done_cnt    <= '0;
      r_clk_cnt     <= '0;
      r_last        <= '0;
      r_error       <= 1'b0;
      r_err_code    <= ERR_NONE;
    end else begin
      r_start_layer <= '0;
      r_pulse       <= 1'b0;
      if (abort) begin
        r_state <= S_IDLE;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            if (start_network) begin
              r_n_layers  <= n_layers;
              r_n_iter    <= n_iter;
              r_wait      <= wait_cycles;
              r_timeout   <= timeout_cycles;
              r_mask      <= ch_mask;
              r_flags     <= '0;
              r_layer_cnt <= '0;
              r_gap_cnt   <= '0;
              r_wait_cnt  <= '0;
              r_iter_cnt  <= '0;
              r_layer_idx <= '0;
              r_done_cnt  <= '0;
              r_clk_cnt   <= '0;
              r_last      <= '0;
              if (ch_mask == '0 || n_layers == '0) begin
                r_state    <= S_ERROR;
                r_error    <= 1'b1;
                r_err_code <= ERR_CFG;
              end else begin
                r_state       <= S_RUN;
                r_error       <= 1'b0;
                r_err_code    <= ERR_NONE;
                r_start_layer <= ch_mask;
                r_pulse       <= 1'b1;
              end
            end
          end
          S_RUN: begin
            r_clk_cnt   <= w_clk_inc;
            r_layer_cnt <= w_layer_inc;
            if (!r_pulse) begin
              r_flags <= r_flags | (done_layer & r_mask);
            end
            if (w_all_done) begin
              r_last <= w_layer_inc;
              if (!w_last_layer) begin
                r_state   <= S_GAP;
                r_gap_cnt <= '0;
              end else begin
                r_done_cnt <= r_done_cnt + DONE_CNT_W'(1);
                r_iter_cnt <= w_iter_next;
                if (w_run_done) begin
                  r_state <= S_DONE;
                end else if (r_wait == '0) begin
                  r_layer_idx   <= '0;
                  r_start_layer <= r_mask;
                  r_pulse       <= 1'b1;
                  r_flags       <= '0;
                  r_layer_cnt   <= '0;
                end else begin
                  r_state    <= S_WAIT_ITER;
                  r_wait_cnt <= '0;
                end
              end
            end else if (w_timeout) begin
              r_state    <= S_ERROR;
              r_error    <= 1'b1;
              r_err_code <= ERR_TIMEOUT;
            end
          end
          S_GAP: begin
            r_clk_cnt <= w_clk_inc;
            if (r_gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
              r_state       <= S_RUN;
              r_layer_idx   <= r_layer_idx + LAYER_W'(1);
              r_start_layer <= r_mask;
              r_pulse       <= 1'b1;
              r_flags       <= '0;
              r_layer_cnt   <= '0;
            end else begin
              r_gap_cnt <= r_gap_cnt + GAP_W'(1);
            end
          end
          S_WAIT_ITER: begin
            r_clk_cnt <= w_clk_inc;
            if (r_wait_cnt == r_wait - WAIT_W'(1)) begin
              r_state       <= S_RUN;
              r_layer_idx   <= '0;
              r_start_layer <= r_mask;
              r_pulse       <= 1'b1;
              r_flags       <= '0;
              r_layer_cnt   <= '0;
            end else begin
              r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
            end
          end
          S_DONE: begin
            if (!start_network) r_state <= S_IDLE;
          end
          S_ERROR: begin
            if (!start_network) r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign start_layer       = r_start_layer;
  assign busy              = (r_state == S_RUN) ||
                             (r_state == S_GAP) ||
                             (r_state == S_WAIT_ITER);
  assign done_network      = (r_state == S_DONE);
  assign error             = r_error;
  assign err_code          = r_err_code;
  assign layer_idx         = r_layer_idx;
  assign done_network_cnt  = r_done_cnt;
  assign clk_cnt           = r_clk_cnt;
  assign last_layer_cycles = r_last;

endmodule
